// File: rtl/ddr3_arb_pkg.sv
// Shared constants for the DDR3 RAM-port arbiter.
package ddr3_arb_pkg;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned ADDR_W = 32;

endpackage

// File: rtl/ddr3_arb_fifo.sv
// Grant-index FIFO: remembers which requester owns each outstanding RAM request.
module ddr3_arb_fifo #(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DEPTH_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [WIDTH-1:0]   wdata_i,
  input  logic               pop_i,
  output logic [WIDTH-1:0]   rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [DEPTH_W:0]   count_o
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [DEPTH_W-1:0] wr_ptr_q;
  logic [DEPTH_W-1:0] rd_ptr_q;
  logic [DEPTH_W:0]   count_q;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == (DEPTH_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full is judged on the pre-pop count, so a full FIFO refuses a push even while popping.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ddr3_ram_arb.sv
// Round-robin arbiter sharing one DDR3 simple RAM port between NUM_REQ requesters.
module ddr3_ram_arb
  import ddr3_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 2,
  parameter int unsigned IDX_W       = 1,
  parameter int unsigned DATA_W      = ddr3_arb_pkg::DATA_W,
  parameter int unsigned OUTSTANDING = 8,
  parameter int unsigned OUT_W       = 3
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_rd_i,
  input  logic [NUM_REQ*DATA_W/8-1:0]   req_wr_i,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata_i,
  output logic [NUM_REQ-1:0]            req_accept_o,
  output logic [NUM_REQ-1:0]            req_ack_o,
  output logic [DATA_W-1:0]             req_rdata_o,
  output logic                          ram_rd_o,
  output logic [DATA_W/8-1:0]           ram_wr_o,
  output logic [ADDR_W-1:0]             ram_addr_o,
  output logic [DATA_W-1:0]             ram_wdata_o,
  input  logic                          ram_accept_i,
  input  logic                          ram_ack_i,
  input  logic [DATA_W-1:0]             ram_rdata_i,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int unsigned SW = DATA_W / 8;

  // First valid requester at or above ptr, else the lowest valid one (wrap-around).
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] first_any;
    logic [IDX_W-1:0] first_hi;
    logic             hi_found;
    first_any = ptr;
    first_hi  = ptr;
    hi_found  = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (valid[j]) first_any = IDX_W'(j);
      if (valid[j] && (j >= 32'(ptr))) begin
        first_hi = IDX_W'(j);
        hi_found = 1'b1;
      end
    end
    return hi_found ? first_hi : first_any;
  endfunction

  logic [NUM_REQ-1:0] valid;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   head;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   lock_idx_q;
  logic               lock_q;
  logic               err_q;
  logic               presented;
  logic               acc;
  logic               pop;
  logic               full;
  logic               empty;
  logic [OUT_W:0]     count;

  // A requester is valid when it asks for a read or drives any write strobe.
  always_comb begin
    valid = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      valid[r] = req_rd_i[r] | (|req_wr_i[r*SW +: SW]);
    end
  end

  // A stalled request keeps the port until accepted, so the core sees a stable request.
  assign grant     = lock_q ? lock_idx_q : rr_pick(valid, rr_ptr_q);
  assign presented = valid[grant] & ~full;
  assign acc       = ram_accept_i & presented;
  assign pop       = ram_ack_i & ~empty;

  ddr3_arb_fifo #(
    .WIDTH   (IDX_W),
    .DEPTH   (OUTSTANDING),
    .DEPTH_W (OUT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (acc),
    .wdata_i (grant),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Forward the granted request to the core and route accept/ack back; all quiet in reset.
  always_comb begin
    ram_rd_o     = 1'b0;
    ram_wr_o     = '0;
    ram_addr_o   = '0;
    ram_wdata_o  = '0;
    req_accept_o = '0;
    req_ack_o    = '0;
    req_rdata_o  = '0;
    if (!rst_i) begin
      if (presented) begin
        ram_rd_o    = req_rd_i[grant];
        ram_wr_o    = req_wr_i[32'(grant)*SW +: SW];
        ram_addr_o  = req_addr_i[32'(grant)*ADDR_W +: ADDR_W];
        ram_wdata_o = req_wdata_i[32'(grant)*DATA_W +: DATA_W];
      end
      if (acc) req_accept_o[grant] = 1'b1;
      if (pop) req_ack_o[head] = 1'b1;
      req_rdata_o = ram_rdata_i;
    end
  end

  assign busy_o = (count != '0);
  assign err_o  = err_q;

  // Round-robin pointer, request lock and sticky empty-ack error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (acc) begin
        rr_ptr_q <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      end
      lock_q <= presented & ~acc;
      if (presented && !acc) lock_idx_q <= grant;
      if (ram_ack_i && empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr3_ram_arb.sv
// Randomised and directed bench for ddr3_ram_arb against a queue-based reference model.
module tb_ddr3_ram_arb;

  localparam int N    = 2;
  localparam int DW   = 128;
  localparam int SW   = DW / 8;
  localparam int OUTS = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    rd;
  logic [N*SW-1:0] wr;
  logic [N*32-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    accept_o;
  logic [N-1:0]    ack_o;
  logic [DW-1:0]   rdata_o;
  logic            ram_rd;
  logic [SW-1:0]   ram_wr;
  logic [31:0]     ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic            ram_accept;
  logic            ram_ack;
  logic [DW-1:0]   ram_rdata;
  logic            busy;
  logic            err;

  always #5 clk = ~clk;

  ddr3_ram_arb dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_rd_i     (rd),
    .req_wr_i     (wr),
    .req_addr_i   (addr),
    .req_wdata_i  (wdata),
    .req_accept_o (accept_o),
    .req_ack_o    (ack_o),
    .req_rdata_o  (rdata_o),
    .ram_rd_o     (ram_rd),
    .ram_wr_o     (ram_wr),
    .ram_addr_o   (ram_addr),
    .ram_wdata_o  (ram_wdata),
    .ram_accept_i (ram_accept),
    .ram_ack_i    (ram_ack),
    .ram_rdata_i  (ram_rdata),
    .busy_o       (busy),
    .err_o        (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: outstanding owners in order, pointer, lock and error flag.
  int q[$];
  int m_rr = 0;
  bit m_lock = 1'b0;
  int m_lock_idx = 0;
  bit m_err = 1'b0;
  int e_g;
  bit e_pres, e_acc, e_pop, e_bad;
  logic [N-1:0] v;
  logic [N-1:0] oh;

  // Compare every cycle mid-low-phase, then advance the model at the clock edge.
  initial forever begin
    @(negedge clk);
    #4;
    if (rst) begin
      check("rst_accept", accept_o, '0);
      check("rst_ack", ack_o, '0);
      check("rst_rd", ram_rd, '0);
      check("rst_wr", ram_wr, '0);
      check("rst_addr", ram_addr, '0);
      check("rst_wdata", ram_wdata, '0);
      check("rst_rdata", rdata_o, '0);
      check("rst_busy", busy, '0);
      check("rst_err", err, '0);
      q.delete();
      m_rr = 0; m_lock = 1'b0; m_lock_idx = 0; m_err = 1'b0;
      e_pres = 1'b0; e_acc = 1'b0; e_pop = 1'b0; e_bad = 1'b0; e_g = 0;
    end else begin
      for (int r = 0; r < N; r++) v[r] = rd[r] || (wr[r*SW +: SW] != '0);
      if (m_lock) begin
        e_g = m_lock_idx;
      end else begin
        e_g = m_rr;
        for (int k = N - 1; k >= 0; k--) if (v[(m_rr + k) % N]) e_g = (m_rr + k) % N;
      end
      e_pres = v[e_g] && (q.size() < OUTS);
      e_acc  = e_pres && ram_accept;
      e_pop  = ram_ack && (q.size() > 0);
      e_bad  = ram_ack && (q.size() == 0);
      oh = '0;
      if (e_acc) oh[e_g] = 1'b1;
      check("accept", accept_o, oh);
      oh = '0;
      if (e_pop) oh[q[0]] = 1'b1;
      check("ack", ack_o, oh);
      if (e_pop) check("rdata", rdata_o, ram_rdata);
      check("ram_rd", ram_rd, e_pres ? rd[e_g] : 1'b0);
      check("ram_wr", ram_wr, e_pres ? wr[e_g*SW +: SW] : '0);
      check("ram_addr", ram_addr, e_pres ? addr[e_g*32 +: 32] : '0);
      check("ram_wdata", ram_wdata, e_pres ? wdata[e_g*DW +: DW] : '0);
      check("busy", busy, q.size() != 0);
      check("err", err, m_err);
    end
    @(posedge clk);
    if (!rst) begin
      if (e_pop) void'(q.pop_front());
      if (e_acc) begin
        q.push_back(e_g);
        m_rr = (e_g + 1) % N;
      end
      m_lock = e_pres && !e_acc;
      if (m_lock) m_lock_idx = e_g;
      if (e_bad) m_err = 1'b1;
    end
  end

  task automatic idle();
    rd = '0; wr = '0; ram_accept = 1'b0; ram_ack = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(negedge clk);
      idle();
      ram_ack = 1'b1;
      ram_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    idle();
  endtask

  int c0, c1;
  logic [N-1:0] seq [4];

  initial begin
    seq = '{2'b01, 2'b10, 2'b10, 2'b01};
    rd = '0; wr = '0; addr = '0; wdata = '0;
    ram_accept = 1'b0; ram_ack = 1'b0; ram_rdata = '0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single read, acked three cycles after acceptance.
    @(negedge clk);
    addr[31:0] = 32'h1000; rd = 2'b01; ram_accept = 1'b1;
    #4;
    check("read_accept", accept_o, 2'b01);
    check("read_addr", ram_addr, 32'h1000);
    check("read_rd", ram_rd, 1'b1);
    @(negedge clk); idle();
    @(negedge clk);
    @(negedge clk);
    ram_ack = 1'b1; ram_rdata = {16{8'hA5}};
    #4;
    check("read_ack", ack_o, 2'b01);
    check("read_rdata", rdata_o, {16{8'hA5}});
    @(negedge clk); ram_ack = 1'b0;
    #4;
    check("read_busy_done", busy, 1'b0);

    // Fairness: both continuously requesting.
    c0 = 0; c1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd = 2'b11; ram_accept = 1'b1;
      #4;
      if (accept_o == 2'b01) c0++;
      if (accept_o == 2'b10) c1++;
    end
    @(negedge clk); idle();
    #4;
    check("fair_req0", c0, 4);
    check("fair_req1", c1, 4);
    drain();

    // Lock: requester 1 stalled while requester 0 competes.
    addr[63:32] = 32'h2000; addr[31:0] = 32'h3000;
    @(negedge clk);
    rd = 2'b10; ram_accept = 1'b0;
    #4;
    check("lock_first", ram_addr, 32'h2000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd = 2'b11;
      #4;
      check("lock_hold", ram_addr, 32'h2000);
      check("lock_noaccept", accept_o, 2'b00);
    end
    @(negedge clk); ram_accept = 1'b1;
    #4;
    check("lock_accept", accept_o, 2'b10);
    @(negedge clk); rd = 2'b01;
    #4;
    check("lock_next", accept_o, 2'b01);
    drain();

    // Full FIFO stalls, including the cycle an ack pops.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd = 2'b01; ram_accept = 1'b1;
      #4;
      check("full_fill", accept_o, 2'b01);
    end
    @(negedge clk);
    #4;
    check("full_stall", accept_o, 2'b00);
    check("full_stall_rd", ram_rd, 1'b0);
    @(negedge clk); ram_ack = 1'b1;
    #4;
    check("full_ack_stall", accept_o, 2'b00);
    check("full_ack", ack_o, 2'b01);
    @(negedge clk); ram_ack = 1'b0;
    #4;
    check("full_resume", accept_o, 2'b01);
    drain();

    // Ack routing follows acceptance order.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd = seq[i]; ram_accept = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle(); ram_ack = 1'b1;
      #4;
      check("route_ack", ack_o, seq[i]);
    end
    @(negedge clk); idle();

    // Ack with nothing outstanding.
    @(negedge clk); ram_ack = 1'b1;
    #4;
    check("err_noack", ack_o, 2'b00);
    @(negedge clk); ram_ack = 1'b0;
    #4;
    check("err_set", err, 1'b1);

    // Random traffic; a locked requester keeps its request stable.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (!(m_lock && m_lock_idx == r) && $urandom_range(0, 2) == 0) begin
          rd[r] = 1'($urandom_range(0, 1));
          wr[r*SW +: SW] = ($urandom_range(0, 3) == 0) ? SW'($urandom) : '0;
          addr[r*32 +: 32] = $urandom;
          wdata[r*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      ram_accept = ($urandom_range(0, 3) != 0);
      ram_ack = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      ram_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
    drain();
    #4;
    check("err_sticky", err, 1'b1);

    // Asynchronous reset with three requests outstanding.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rd = 2'b01; ram_accept = 1'b1;
    end
    @(negedge clk);
    #4;
    check("pre_rst_busy", busy, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #2;
    check("async_rst_rd", ram_rd, 1'b0);
    check("async_rst_accept", accept_o, 2'b00);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_err", err, 1'b0);
    @(negedge clk); idle();
    @(negedge clk); rst = 1'b0;
    #4;
    check("post_rst_busy", busy, 1'b0);
    @(negedge clk); rd = 2'b01; ram_accept = 1'b1;
    #4;
    check("post_rst_accept", accept_o, 2'b01);
    @(negedge clk); idle();
    @(negedge clk);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
